uart_rx: RTL and testbench

- Oversampling UART receiver.
- Deserialises the i_rx line into DBIT-wide words using a 16x baud tick from the shared baud generator.
- Emits a one-cycle done tick with the received word. The done tick and word feed the downstream flag buffer's set-flag and data inputs directly.
- Sits between the board pin (after the synchroniser) and the rx flag buffer.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_rx.sv | 173 +++++++++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling constants and
// default frame parameters used by both uart_rx and uart_tx.
// Configuration macro: UART_RX_PARITY_EN adds a PARITY state, widening the
// state encoding to 3 bits.
package uart_pkg;

  localparam int OVERSAMPLE  = 16;
  localparam int START_MID   = 7;
  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    STOP   = 3'b011,
    PARITY = 3'b100
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } state_t;
`endif

endpackage

// File: rtl/uart_rx.sv
// Oversampling UART receiver. Samples each bit at its midpoint using a 16x
// baud tick and emits a one-cycle done pulse with the received word.
// Configuration macro: UART_RX_PARITY_EN (even parity bit after the data).
// Ports:
//   i_clk          system clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_rx           synchronised serial line, idle high
//   i_s_tick       one-cycle pulse at 16x the baud rate
//   o_rx_done_tick one-cycle pulse when a frame completes
//   o_dout         received word (LSB first on the line)
//   o_frame_err    stop bit sampled low in the last completed frame
//   o_parity_err   parity mismatch in the last completed frame
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic            o_rx_done_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_frame_err,
  output logic            o_parity_err
);

  // The tick counter stays 4 bits for one stop bit and grows only when a
  // longer stop period needs to be counted.
  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic [DBIT-1:0]   dout_q, dout_d;
  logic              ferr_q, ferr_d;
  logic              done_q, done_d;
`ifdef UART_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      ferr_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      ferr_q  <= ferr_d;
      done_q  <= done_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      // A falling edge is caught on any clock; the counter restarts so a
      // tick coinciding with the edge is not counted.
      IDLE: begin
        if (!i_rx) begin
          state_d = START;
          s_d     = '0;
        end
      end
      // Re-check the line at the middle of the start bit to reject glitches.
      START: begin
        if (i_s_tick) begin
          if (s_q == SW'(START_MID)) begin
            if (!i_rx) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      // Sampling one full bit period after mid-start lands mid-bit.
      DATA: begin
        if (i_s_tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            shift_d = {i_rx, shift_q[DBIT-1:1]};
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (i_s_tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            par_d   = i_rx;
            state_d = STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
`endif
      // Frame results are committed together on the last stop-bit tick.
      STOP: begin
        if (i_s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            dout_d  = shift_q;
            ferr_d  = ~i_rx;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shift_q) ^ par_q;
`endif
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rx_done_tick = done_q;
  assign o_dout         = dout_q;
  assign o_frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err   = perr_q;
`else
  assign o_parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic       done;
  logic [7:0] dout;
  logic       ferr;
  logic       perr;

  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  logic [7:0] last_d = 8'h00;
  logic [7:0] prev_d = 8'h00;
  logic [3:0] tcnt = 4'd0;

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .i_clk          (clk),
    .i_reset_n      (rst_n),
    .i_rx           (rx),
    .i_s_tick       (s_tick),
    .o_rx_done_tick (done),
    .o_dout         (dout),
    .o_frame_err    (ferr),
    .o_parity_err   (perr)
  );

  always #5 clk = ~clk;

  // Baud tick every 10 clocks, changed on the falling edge.
  always @(negedge clk) begin
    if (tcnt == 4'd9) begin
      tcnt   <= 4'd0;
      s_tick <= 1'b1;
    end else begin
      tcnt   <= tcnt + 4'd1;
      s_tick <= 1'b0;
    end
  end

  // Every high cycle of done is counted, so a stretched pulse shows up.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt <= done_cnt + 1;
      prev_d   <= last_d;
      last_d   <= dout;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (s_tick !== 1'b1) @(posedge clk);
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, input logic parb);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
`ifdef UART_RX_PARITY_EN
    rx = parb;
    wait_ticks(16);
`else
    if (parb) rx = 1'b0;
`endif
    // Stop level held through the receiver's sample point, then idle.
    rx = stopb;
    wait_ticks(8);
    rx = 1'b1;
    wait_ticks(8);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", ferr); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", perr); end
    rst_n = 1'b1;
    wait_ticks(2);
  endtask

  task automatic test_basic;
    int c0;
    c0 = done_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL basic_done_cycles got %0d exp 1", done_cnt - c0); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_dout got %h exp a5", dout); end
    checks++; if (last_d !== 8'hA5) begin errors++; $display("FAIL basic_dout_at_done got %h exp a5", last_d); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b exp 0", ferr); end
  endtask

  task automatic test_false_start;
    int c0;
    c0 = done_cnt;
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(20);
    checks++; if (done_cnt !== c0) begin errors++; $display("FAIL false_start_done got %0d exp %0d", done_cnt, c0); end
    checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL false_start_state got %0d exp %0d", dut.state_q, IDLE); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL false_start_dout got %h exp a5", dout); end
  endtask

  task automatic test_frame_err;
    int c0;
    c0 = done_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL ferr_done got %0d exp 1", done_cnt - c0); end
    checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL ferr_dout got %h exp 3c", dout); end
    checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", ferr); end
    send_frame(8'h01, 1'b1, 1'b0);
    checks++; if (done_cnt - c0 !== 2) begin errors++; $display("FAIL ferr_clean_done got %0d exp 2", done_cnt - c0); end
    checks++; if (dout !== 8'h01) begin errors++; $display("FAIL ferr_clean_dout got %h exp 01", dout); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL ferr_clean_flag got %b exp 0", ferr); end
  endtask

  task automatic test_reset_mid_frame;
    int c0;
    c0 = done_cnt;
    rx = 1'b0;
    wait_ticks(16);
    rx = 1'b1;
    wait_ticks(64);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL midreset_dout got %h exp 00", dout); end
    rst_n = 1'b1;
    wait_ticks(16);
    checks++; if (done_cnt !== c0) begin errors++; $display("FAIL midreset_no_done got %0d exp %0d", done_cnt, c0); end
    send_frame(8'h12, 1'b1, 1'b0);
    checks++; if (done_cnt - c0 !== 1) begin errors++; $display("FAIL midreset_done got %0d exp 1", done_cnt - c0); end
    checks++; if (dout !== 8'h12) begin errors++; $display("FAIL midreset_dout2 got %h exp 12", dout); end
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = done_cnt;
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'hAA, 1'b1, 1'b0);
    checks++; if (done_cnt - c0 !== 2) begin errors++; $display("FAIL b2b_done got %0d exp 2", done_cnt - c0); end
    checks++; if (prev_d !== 8'h55) begin errors++; $display("FAIL b2b_first got %h exp 55", prev_d); end
    checks++; if (last_d !== 8'hAA) begin errors++; $display("FAIL b2b_second got %h exp aa", last_d); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL b2b_perr got %b exp 0", perr); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    send_frame(8'h07, 1'b1, 1'b1);
    checks++; if (dout !== 8'h07) begin errors++; $display("FAIL parity_ok_dout got %h exp 07", dout); end
    checks++; if (perr !== 1'b0) begin errors++; $display("FAIL parity_ok_flag got %b exp 0", perr); end
    send_frame(8'h07, 1'b1, 1'b0);
    checks++; if (perr !== 1'b1) begin errors++; $display("FAIL parity_bad_flag got %b exp 1", perr); end
    checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL parity_bad_ferr got %b exp 0", ferr); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_false_start;
    test_frame_err;
    test_reset_mid_frame;
    test_back_to_back;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
